mem_req_ctrl: RTL and testbench
===============================

Name: mem_req_ctrl

Overview:
Request front-end that sits directly upstream of the single-port memory and drives its write_en/read_en/address/data_in. It also captures data_out/valid_out. Masters push write/read commands through a valid/ready request port into a small in-order FIFO. The controller issues one command at a time to the memory and returns each read result on a valid/ready response port. Writes produce no response.

Parameters:
DATA_WIDTH, 32, memory word width
ADDRESS_WIDTH, 4, memory address width (depth 2**ADDRESS_WIDTH)
FIFO_DEPTH, 4, request FIFO entries; power of 2, >= 2

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request offered
req_ready  out  1  FIFO can accept
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDRESS_WIDTH  target address
req_wdata  in  DATA_WIDTH  write data (ignored for reads)
rsp_valid  out  1  read response available
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  DATA_WIDTH  read data
rsp_addr  out  ADDRESS_WIDTH  address of the read
rsp_err  out  1  memory did not assert valid_out
mem_write_en  out  1  to memory write_en
mem_read_en  out  1  to memory read_en
mem_address  out  ADDRESS_WIDTH  to memory address
mem_data_in  out  DATA_WIDTH  to memory data_in
mem_data_out  in  DATA_WIDTH  from memory data_out
mem_valid_out  in  1  from memory valid_out
busy  out  1  FIFO non-empty or state != IDLE

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Every flop, including the FIFO pointers and count, clears on the clk edge with rst=1.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_addr=0, rsp_err=0, mem_write_en=0, mem_read_en=0, mem_address=0, mem_data_in=0, busy=0, state=IDLE.
- Request handshake: push occurs on an edge where req_valid && req_ready. req_ready = !full and is registered-count based. When full, no push happens even if a pop occurs the same cycle.
- FIFO: stores {write, addr, wdata}. Pointers wrap modulo FIFO_DEPTH. The count is tracked to distinguish full from empty.
- FSM states are IDLE, WRITE, READ, WAIT, RESP.
- IDLE: if the FIFO is non-empty, pop the head into the issue register (addr, wdata, write). Go to WRITE if write=1, else READ. If empty, stay in IDLE.
- WRITE: mem_write_en=1 for exactly one cycle. Next state is IDLE.
- READ: mem_read_en=1 for exactly one cycle. Next state is WAIT.
- WAIT: sample mem_valid_out. If 1, set rsp_rdata=mem_data_out, rsp_err=0. If 0, set rsp_rdata=0, rsp_err=1. In both cases set rsp_addr=issue addr and go to RESP.
- RESP: rsp_valid=1, and rsp_* stay stable while rsp_ready=0. On rsp_valid && rsp_ready, go to IDLE.
- mem_write_en and mem_read_en are decoded from the state register only. They are never both 1.
- mem_address and mem_data_in equal the issue register, held from the pop until the next pop.
- Ordering is strictly in order. A read after a write to the same address returns the new data.
- Latency from a request accepted on edge E0 with the FIFO empty and the FSM in IDLE:
  - Pop happens at E1.
  - WRITE/READ is driven in the cycle after E1.
  - For a read, WAIT follows, and rsp_valid goes high 4 cycles after E0.
  - A write occupies the memory 2 cycles after E0.
- Throughput: one bubble (IDLE) between commands. New requests are accepted while the FSM is busy, up to FIFO_DEPTH.
- Reset mid-operation: queued and in-flight commands are dropped and no response is produced. A write interrupted in the WRITE cycle by rst is not issued, because outputs go low on that edge.
- Addresses wrap naturally at 2**ADDRESS_WIDTH-1. No range check is performed.

Decomposition:
- Package mem_req_ctrl_pkg holds:
  - the state enum (IDLE, WRITE, READ, WAIT, RESP);
  - a packed request struct {write, addr, wdata} parameterised via localparams DATA_WIDTH=32 and ADDRESS_WIDTH=4;
  - localparam FIFO_DEPTH.
- One sub-module: mem_req_fifo, a synchronous FIFO with push/pop/full/empty/count and synchronous active-high reset, instantiated once.

Test Plan:
- Write 0xDEADBEEF to addr 3, then read addr 3 -> mem_write_en pulses once with address 3. rsp_valid rises 4 cycles after the read handshake with rsp_rdata=0xDEADBEEF, rsp_addr=3, rsp_err=0.
- Hold rsp_ready=0 and push 6 reads back-to-back -> first pops, 4 queue, req_ready=0 and 6th stalls. rsp_* stay stable. Releasing rsp_ready drains the responses in order.
- Write 0x1 to addr 15, write 0x2 to addr 0, then read 15 and read 0 -> responses 0x1 then 0x2. Confirms wrap and no aliasing.
- Bench forces mem_valid_out=0 in WAIT for a read of addr 7 -> rsp_err=1, rsp_rdata=0, rsp_addr=7. The next read returns rsp_err=0.
- Assert rst for 1 cycle while in WAIT with 2 queued requests -> all outputs return to reset values, busy=0, and no rsp_valid ever appears for the dropped commands.
- Throughout, assertion checks that mem_write_en && mem_read_en is never 1.

Source files
------------

// File: rtl/mem_req_ctrl_pkg.sv
// Shared types for the memory request front-end: FSM states, the queued
// request layout and the default sizing.
package mem_req_ctrl_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int ADDRESS_WIDTH = 4;
  localparam int FIFO_DEPTH    = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_e;

  typedef struct packed {
    logic                     write;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    wdata;
  } req_t;

  localparam int REQ_W = $bits(req_t);

endpackage

// File: rtl/mem_req_fifo.sv
// Small in-order request FIFO. Push is ignored when full and pop when empty,
// so a full FIFO never accepts even if it drains on the same edge.
module mem_req_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Request front-end for the single-port memory: queues write/read commands,
// issues them one at a time and returns read results on a valid/ready port.
module mem_req_ctrl
  import mem_req_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = mem_req_ctrl_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = mem_req_ctrl_pkg::ADDRESS_WIDTH,
  parameter int FIFO_DEPTH    = mem_req_ctrl_pkg::FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic [ADDRESS_WIDTH-1:0] rsp_addr,
  output logic                     rsp_err,
  output logic                     mem_write_en,
  output logic                     mem_read_en,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_data_in,
  input  logic [DATA_WIDTH-1:0]    mem_data_out,
  input  logic                     mem_valid_out,
  output logic                     busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e  state_q, state_d;
  req_t    issue_q, push_req, head_req;
  logic    fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  logic [DATA_WIDTH-1:0]    rsp_rdata_q;
  logic [ADDRESS_WIDTH-1:0] rsp_addr_q;
  logic                     rsp_err_q;

  assign push_req = '{write: req_write, addr: req_addr, wdata: req_wdata};

  mem_req_fifo #(
    .W     (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_valid),
    .wdata_i (push_req),
    .pop_i   (fifo_pop),
    .rdata_o (head_req),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = head_req.write ? WRITE : READ;
        end
      end
      WRITE:   state_d = IDLE;
      READ:    state_d = WAIT;
      WAIT:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_addr_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fifo_pop) issue_q <= head_req;
      // A missing valid_out is reported as an error with zeroed data.
      if (state_q == WAIT) begin
        rsp_rdata_q <= mem_valid_out ? mem_data_out : '0;
        rsp_err_q   <= !mem_valid_out;
        rsp_addr_q  <= issue_q.addr;
      end
    end
  end

  assign req_ready    = !fifo_full;
  assign rsp_valid    = (state_q == RESP);
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_addr     = rsp_addr_q;
  assign rsp_err      = rsp_err_q;
  assign mem_write_en = (state_q == WRITE);
  assign mem_read_en  = (state_q == READ);
  assign mem_address  = issue_q.addr;
  assign mem_data_in  = issue_q.wdata;
  assign busy         = (fifo_count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a behavioural single-port memory.
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  rsp_addr;
  logic        mem_write_en, mem_read_en, mem_valid_out;
  logic [3:0]  mem_address;
  logic [31:0] mem_data_in, mem_data_out;
  logic        busy;

  int nvec = 0;
  int nmis = 0;

  logic [31:0] mem [16];
  logic        kill_valid;
  int          wr_pulses;
  int          rsp_seen;
  logic [31:0] q_data [$];
  logic [3:0]  q_addr [$];
  logic        q_err  [$];

  always #5 clk = ~clk;

  mem_req_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_addr      (rsp_addr),
    .rsp_err       (rsp_err),
    .mem_write_en  (mem_write_en),
    .mem_read_en   (mem_read_en),
    .mem_address   (mem_address),
    .mem_data_in   (mem_data_in),
    .mem_data_out  (mem_data_out),
    .mem_valid_out (mem_valid_out),
    .busy          (busy)
  );

  function automatic logic [31:0] init_val(input int a);
    return 32'hC0DE_0000 + 32'(a);
  endfunction

  // Memory: registered read, valid_out one cycle after read_en.
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_address] <= mem_data_in;
    if (mem_read_en) begin
      mem_data_out  <= mem[mem_address];
      mem_valid_out <= !kill_valid;
    end else begin
      mem_valid_out <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("wr_rd_excl", 64'(mem_write_en & mem_read_en), 64'd0);
    if (mem_write_en) wr_pulses++;
    if (rsp_valid) rsp_seen++;
    if (rsp_valid && rsp_ready) begin
      q_data.push_back(rsp_rdata);
      q_addr.push_back(rsp_addr);
      q_err.push_back(rsp_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic w, input logic [3:0] a, input logic [31:0] d);
    bit ok = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
      tick();
    end
    if (!ok) chk("push_timeout", 64'd0, 64'd1);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1;
    end
    if (!ok) chk("idle_timeout", 64'd0, 64'd1);
    tick();
  endtask

  task automatic exp_rsp(input int idx, input logic [31:0] d, input logic [3:0] a, input logic e);
    if (idx < q_data.size()) begin
      chk($sformatf("rsp%0d_data", idx), 64'(q_data[idx]), 64'(d));
      chk($sformatf("rsp%0d_addr", idx), 64'(q_addr[idx]), 64'(a));
      chk($sformatf("rsp%0d_err", idx), 64'(q_err[idx]), 64'(e));
    end else begin
      chk($sformatf("rsp%0d_missing", idx), 64'd0, 64'd1);
    end
  endtask

  task automatic clear_q();
    q_data.delete();
    q_addr.delete();
    q_err.delete();
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({pfx, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    chk({pfx, "_rsp_addr"},  64'(rsp_addr), 64'd0);
    chk({pfx, "_rsp_err"},   64'(rsp_err), 64'd0);
    chk({pfx, "_wr_en"},     64'(mem_write_en), 64'd0);
    chk({pfx, "_rd_en"},     64'(mem_read_en), 64'd0);
    chk({pfx, "_mem_addr"},  64'(mem_address), 64'd0);
    chk({pfx, "_mem_din"},   64'(mem_data_in), 64'd0);
    chk({pfx, "_busy"},      64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; kill_valid = 1'b0; wr_pulses = 0; rsp_seen = 0;
    mem_data_out = '0; mem_valid_out = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = init_val(i);

    repeat (3) tick();
    @(negedge clk);
    chk_reset_outputs("rst0");
    tick();
    rst = 1'b0;

    // Write then read the same address, with latency checks.
    wr_pulses = 0;
    push(1'b1, 4'd3, 32'hDEAD_BEEF);
    n = 0;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      @(negedge clk);
      if (mem_write_en) n = i;
    end
    chk("wr_latency", 64'(n), 64'd2);
    chk("wr_addr", 64'(mem_address), 64'd3);
    chk("wr_data", 64'(mem_data_in), 64'hDEAD_BEEF);
    wait_idle();
    chk("wr_pulses", 64'(wr_pulses), 64'd1);

    clear_q();
    push(1'b0, 4'd3, 32'd0);
    n = 0;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      @(negedge clk);
      if (rsp_valid) n = i;
    end
    chk("rd_latency", 64'(n), 64'd4);
    wait_idle();
    chk("rd_count", 64'(q_data.size()), 64'd1);
    exp_rsp(0, 32'hDEAD_BEEF, 4'd3, 1'b0);

    // Backpressure: five reads fill issue + FIFO, the sixth must stall.
    clear_q();
    rsp_ready = 1'b0;
    push(1'b0, 4'd1, 32'd0);
    push(1'b0, 4'd2, 32'd0);
    push(1'b0, 4'd4, 32'd0);
    push(1'b0, 4'd5, 32'd0);
    push(1'b0, 4'd6, 32'd0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd8;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_addr",  64'(rsp_addr), 64'd1);
      chk("bp_rsp_rdata", 64'(rsp_rdata), 64'(init_val(1)));
      chk("bp_busy",      64'(busy), 64'd1);
    end
    tick();
    rsp_ready = 1'b1;
    push(1'b0, 4'd8, 32'd0);
    wait_idle();
    chk("bp_count", 64'(q_data.size()), 64'd6);
    exp_rsp(0, init_val(1), 4'd1, 1'b0);
    exp_rsp(1, init_val(2), 4'd2, 1'b0);
    exp_rsp(2, init_val(4), 4'd4, 1'b0);
    exp_rsp(3, init_val(5), 4'd5, 1'b0);
    exp_rsp(4, init_val(6), 4'd6, 1'b0);
    exp_rsp(5, init_val(8), 4'd8, 1'b0);

    // Top and bottom addresses do not alias.
    clear_q();
    push(1'b1, 4'd15, 32'h1);
    push(1'b1, 4'd0,  32'h2);
    push(1'b0, 4'd15, 32'd0);
    push(1'b0, 4'd0,  32'd0);
    wait_idle();
    chk("wrap_count", 64'(q_data.size()), 64'd2);
    exp_rsp(0, 32'h1, 4'd15, 1'b0);
    exp_rsp(1, 32'h2, 4'd0, 1'b0);

    // Memory withholds valid_out: error response, then a clean read.
    clear_q();
    kill_valid = 1'b1;
    push(1'b0, 4'd7, 32'd0);
    wait_idle();
    kill_valid = 1'b0;
    push(1'b0, 4'd7, 32'd0);
    wait_idle();
    chk("err_count", 64'(q_data.size()), 64'd2);
    exp_rsp(0, 32'd0, 4'd7, 1'b1);
    exp_rsp(1, init_val(7), 4'd7, 1'b0);

    // Reset while the first read sits in WAIT with two more queued.
    clear_q();
    push(1'b0, 4'd9, 32'd0);
    push(1'b0, 4'd10, 32'd0);
    push(1'b0, 4'd11, 32'd0);
    rsp_seen = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst1");
    repeat (20) @(negedge clk);
    chk("rst1_no_rsp", 64'(rsp_seen), 64'd0);
    chk("rst1_idle_busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
